// File: rtl/gate_lane_arbiter_pkg.sv
// Shared types and defaults for the parking gate lane arbiter.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OPEN  = 2'b01,
    CLOSE = 2'b10
  } gate_state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

  localparam int DEFAULT_CAPACITY       = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  function automatic lane_t other_lane(input lane_t lane);
    return (lane == LANE_ENTRY) ? LANE_EXIT : LANE_ENTRY;
  endfunction

endpackage

// File: rtl/gate_lane_arbiter_occupancy_counter.sv
// Saturating lot occupancy counter with full/empty flags.
module occupancy_counter
  import gate_pkg::*;
#(
  parameter  int CAPACITY = DEFAULT_CAPACITY,
  localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] count,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
    end else if (dec && !empty) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == OCC_W'(CAPACITY));
  assign empty = (count == '0);

  // Eligibility upstream must keep the counter away from both rails.
  a_no_wrap: assert property (@(posedge clk) disable iff (rst)
    !(inc && full) && !(dec && empty));

endmodule

// File: rtl/gate_lane_arbiter.sv
// Shared barrier gate arbiter for an entry and an exit lane with occupancy tracking.
// Optional OPEN-state watchdog enabled by defining GATE_TIMEOUT_EN.
module gate_lane_arbiter
  import gate_pkg::*;
#(
  parameter  int CAPACITY       = DEFAULT_CAPACITY,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int OCC_W          = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             vehicle_passed,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic             gate_close,
  output logic [OCC_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             timeout_alarm,
  output gate_state_t      state
);

  if (CAPACITY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("gate_lane_arbiter: CAPACITY and TIMEOUT_CYCLES must be >= 1");
  end

  gate_state_t state_q, state_d;
  lane_t       owner_q, owner_d;
  lane_t       rr_q, rr_d;        // lane favoured on a tie: the one not served last
  logic        inc, dec;
  logic        entry_ok, exit_ok;
  logic        timed_out;

  occupancy_counter #(.CAPACITY(CAPACITY)) u_occ (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (occupancy),
    .full  (lot_full),
    .empty (lot_empty)
  );

  assign entry_ok = entry_req && !lot_full;
  assign exit_ok  = exit_req && !lot_empty;

`ifdef GATE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timed_out_q, timed_out_d;
  logic             expire;

  assign expire    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timed_out = timed_out_q;

  // Counter sits at zero outside OPEN, so each OPEN visit starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= (state_q == OPEN) ? cnt_q + 1'b1 : '0;
      timed_out_q <= timed_out_d;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= LANE_ENTRY;
      rr_q    <= LANE_ENTRY;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    inc     = 1'b0;
    dec     = 1'b0;
`ifdef GATE_TIMEOUT_EN
    timed_out_d = timed_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (entry_ok && exit_ok) begin
          owner_d = rr_q;
          rr_d    = other_lane(rr_q);
          state_d = OPEN;
        end else if (entry_ok) begin
          owner_d = LANE_ENTRY;
          rr_d    = LANE_EXIT;
          state_d = OPEN;
        end else if (exit_ok) begin
          owner_d = LANE_EXIT;
          rr_d    = LANE_ENTRY;
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (vehicle_passed) begin
          state_d = CLOSE;
`ifdef GATE_TIMEOUT_EN
          timed_out_d = 1'b0;
        end else if (expire) begin
          state_d     = CLOSE;
          timed_out_d = 1'b1;
`endif
        end
      end
      CLOSE: begin
        state_d = IDLE;
        inc     = !timed_out && (owner_q == LANE_ENTRY);
        dec     = !timed_out && (owner_q == LANE_EXIT);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    entry_grant   = 1'b0;
    exit_grant    = 1'b0;
    gate_open     = 1'b0;
    gate_close    = 1'b0;
    timeout_alarm = 1'b0;
    if (state_q == OPEN || state_q == CLOSE) begin
      entry_grant = (owner_q == LANE_ENTRY);
      exit_grant  = (owner_q == LANE_EXIT);
    end
    gate_open  = (state_q == OPEN);
    gate_close = (state_q == CLOSE);
    timeout_alarm = (state_q == CLOSE) && timed_out;
  end

  assign state = state_q;

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Scenario bench for gate_lane_arbiter; occupancy updates checked from an expected queue.
module tb_gate_lane_arbiter;
  import gate_pkg::*;

  localparam int CAP   = 8;
  localparam int TO    = 16;
  localparam int OCC_W = $clog2(CAP + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             entry_req, exit_req, vehicle_passed;
  logic             entry_grant, exit_grant, gate_open, gate_close;
  logic [OCC_W-1:0] occupancy;
  logic             lot_full, lot_empty, timeout_alarm;
  gate_state_t      state;

  int               checks = 0;
  int               errors = 0;
  int               occ_m;
  lane_t            rr_m;
  logic [OCC_W-1:0] exp_q[$];
  logic [OCC_W-1:0] exp_occ;
  bit               close_seen;

  gate_lane_arbiter #(.CAPACITY(CAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .entry_req      (entry_req),
    .exit_req       (exit_req),
    .vehicle_passed (vehicle_passed),
    .entry_grant    (entry_grant),
    .exit_grant     (exit_grant),
    .gate_open      (gate_open),
    .gate_close     (gate_close),
    .occupancy      (occupancy),
    .lot_full       (lot_full),
    .lot_empty      (lot_empty),
    .timeout_alarm  (timeout_alarm),
    .state          (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // The cycle after each CLOSE must show the expected occupancy.
  always @(negedge clk) begin
    if (rst) begin
      close_seen = 1'b0;
    end else begin
      if (close_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL occ_update: close with no expectation, occupancy=%0d", occupancy);
        end else begin
          exp_occ = exp_q.pop_front();
          if (occupancy !== exp_occ) begin
            errors++;
            $display("FAIL occ_update: occupancy=%0d expected=%0d", occupancy, exp_occ);
          end
        end
      end
      close_seen = gate_close;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    vehicle_passed = 1'b0;
    step();
    step();
    rst = 1'b0;
    occ_m = 0;
    rr_m = LANE_ENTRY;
    exp_q.delete();
    step();
  endtask

  task automatic wait_open(output bit ok);
    for (int i = 0; i < 8; i++) begin
      if (gate_open) break;
      step();
    end
    ok = gate_open;
  endtask

  task automatic serve(input lane_t lane);
    bit ok;
    if (lane == LANE_ENTRY) entry_req = 1'b1;
    else exit_req = 1'b1;
    step();
    entry_req = 1'b0;
    exit_req = 1'b0;
    wait_open(ok);
    checks++;
    if (!ok || entry_grant !== (lane == LANE_ENTRY) || exit_grant !== (lane == LANE_EXIT)) begin
      errors++;
      $display("FAIL serve_grant: open=%b entry_grant=%b exit_grant=%b expected lane=%0d",
               gate_open, entry_grant, exit_grant, lane);
    end
    vehicle_passed = 1'b1;
    occ_m += (lane == LANE_ENTRY) ? 1 : -1;
    exp_q.push_back(OCC_W'(occ_m));
    rr_m = other_lane(lane);
    step();
    vehicle_passed = 1'b0;
    checks++;
    if (gate_close !== 1'b1 || gate_open !== 1'b0) begin
      errors++;
      $display("FAIL serve_close: gate_close=%b gate_open=%b expected 1/0", gate_close, gate_open);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    vehicle_passed = 1'b0;
    step();
    checks++;
    if (state !== IDLE || entry_grant !== 1'b0 || exit_grant !== 1'b0 || gate_open !== 1'b0 ||
        gate_close !== 1'b0 || timeout_alarm !== 1'b0 || occupancy !== '0 ||
        lot_empty !== 1'b1 || lot_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d eg=%b xg=%b open=%b close=%b alarm=%b occ=%0d empty=%b full=%b",
               state, entry_grant, exit_grant, gate_open, gate_close, timeout_alarm, occupancy,
               lot_empty, lot_full);
    end
    rst = 1'b0;
    occ_m = 0;
    rr_m = LANE_ENTRY;
    step();
  endtask

  task automatic test_first_entry();
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    checks++;
    if (entry_grant !== 1'b1 || gate_open !== 1'b1 || exit_grant !== 1'b0) begin
      errors++;
      $display("FAIL first_grant_latency: eg=%b open=%b xg=%b expected 1/1/0",
               entry_grant, gate_open, exit_grant);
    end
    step();
    step();
    checks++;
    if (gate_open !== 1'b1 || state !== OPEN) begin
      errors++;
      $display("FAIL first_hold_open: open=%b state=%0d expected 1/OPEN", gate_open, state);
    end
    vehicle_passed = 1'b1;
    occ_m = 1;
    exp_q.push_back(OCC_W'(occ_m));
    rr_m = LANE_EXIT;
    step();
    vehicle_passed = 1'b0;
    checks++;
    if (gate_close !== 1'b1 || entry_grant !== 1'b1 || gate_open !== 1'b0) begin
      errors++;
      $display("FAIL first_close: close=%b eg=%b open=%b expected 1/1/0",
               gate_close, entry_grant, gate_open);
    end
    step();
    checks++;
    if (occupancy !== 4'd1 || state !== IDLE || entry_grant !== 1'b0 || lot_empty !== 1'b0) begin
      errors++;
      $display("FAIL first_occ: occ=%0d state=%0d eg=%b empty=%b expected 1/IDLE/0/0",
               occupancy, state, entry_grant, lot_empty);
    end
  endtask

  task automatic test_exit_when_empty();
    apply_reset();
    exit_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (exit_grant !== 1'b0 || gate_open !== 1'b0 || state !== IDLE || lot_empty !== 1'b1) begin
        errors++;
        $display("FAIL empty_exit_ignored: cycle=%0d xg=%b open=%b state=%0d empty=%b",
                 i, exit_grant, gate_open, state, lot_empty);
      end
    end
    exit_req = 1'b0;
    step();
  endtask

  task automatic test_fill();
    while (occ_m < CAP) serve(LANE_ENTRY);
    checks++;
    if (lot_full !== 1'b1 || occupancy !== OCC_W'(CAP)) begin
      errors++;
      $display("FAIL fill_full: full=%b occ=%0d expected 1/%0d", lot_full, occupancy, CAP);
    end
    entry_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (entry_grant !== 1'b0 || gate_open !== 1'b0 || state !== IDLE) begin
        errors++;
        $display("FAIL full_entry_ignored: cycle=%0d eg=%b open=%b state=%0d",
                 i, entry_grant, gate_open, state);
      end
    end
    entry_req = 1'b0;
    serve(LANE_EXIT);
    checks++;
    if (occupancy !== OCC_W'(CAP - 1) || lot_full !== 1'b0) begin
      errors++;
      $display("FAIL full_exit: occ=%0d full=%b expected %0d/0", occupancy, lot_full, CAP - 1);
    end
  endtask

  task automatic test_alternate();
    bit    ok;
    lane_t exp_lane;
    while (occ_m > 3) serve(LANE_EXIT);
    entry_req = 1'b1;
    exit_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_open(ok);
      exp_lane = rr_m;
      checks++;
      if (!ok || entry_grant !== (exp_lane == LANE_ENTRY) || exit_grant !== (exp_lane == LANE_EXIT)) begin
        errors++;
        $display("FAIL rr_grant: round=%0d open=%b eg=%b xg=%b expected lane=%0d",
                 k, gate_open, entry_grant, exit_grant, exp_lane);
      end
      vehicle_passed = 1'b1;
      occ_m += (exp_lane == LANE_ENTRY) ? 1 : -1;
      exp_q.push_back(OCC_W'(occ_m));
      rr_m = other_lane(exp_lane);
      if (k == 3) begin
        entry_req = 1'b0;
        exit_req = 1'b0;
      end
      step();
      vehicle_passed = 1'b0;
      step();
    end
    checks++;
    if (occupancy !== 4'd3 || state !== IDLE) begin
      errors++;
      $display("FAIL rr_occ: occ=%0d state=%0d expected 3/IDLE", occupancy, state);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    bit bad;
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    wait_open(ok);
    rr_m = LANE_EXIT;
`ifdef GATE_TIMEOUT_EN
    exp_q.push_back(OCC_W'(occ_m));
    n = 0;
    while (gate_open && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (!ok || n != TO || gate_close !== 1'b1 || timeout_alarm !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expiry: open_cycles=%0d close=%b alarm=%b expected %0d/1/1",
               n, gate_close, timeout_alarm, TO);
    end
    step();
    checks++;
    if (timeout_alarm !== 1'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL timeout_pulse: alarm=%b state=%0d expected 0/IDLE", timeout_alarm, state);
    end
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    wait_open(ok);
    for (int i = 0; i < TO - 1; i++) step();
    checks++;
    if (!ok || gate_open !== 1'b1) begin
      errors++;
      $display("FAIL timeout_last_cycle: open=%b expected 1", gate_open);
    end
    vehicle_passed = 1'b1;
    occ_m++;
    exp_q.push_back(OCC_W'(occ_m));
    step();
    vehicle_passed = 1'b0;
    checks++;
    if (gate_close !== 1'b1 || timeout_alarm !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tie: close=%b alarm=%b expected 1/0", gate_close, timeout_alarm);
    end
    step();
`else
    bad = !ok;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gate_open !== 1'b1 || timeout_alarm !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_timeout_hold: open=%b alarm=%b expected 1/0 throughout", gate_open, timeout_alarm);
    end
    vehicle_passed = 1'b1;
    occ_m++;
    exp_q.push_back(OCC_W'(occ_m));
    step();
    vehicle_passed = 1'b0;
    checks++;
    if (gate_close !== 1'b1 || timeout_alarm !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_close: close=%b alarm=%b expected 1/0", gate_close, timeout_alarm);
    end
    step();
    n = 0;
`endif
  endtask

  task automatic test_reset_mid_open();
    bit ok;
    while (occ_m < 5) serve(LANE_ENTRY);
    while (occ_m > 5) serve(LANE_EXIT);
    checks++;
    if (occupancy !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_occ: occ=%0d expected 5", occupancy);
    end
    entry_req = 1'b1;
    step();
    entry_req = 1'b0;
    wait_open(ok);
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || gate_open !== 1'b0 || entry_grant !== 1'b0 || exit_grant !== 1'b0 ||
        gate_close !== 1'b0 || occupancy !== '0 || lot_empty !== 1'b1 || lot_full !== 1'b0 ||
        state !== IDLE || timeout_alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_open: was_open=%b open=%b eg=%b xg=%b close=%b occ=%0d empty=%b full=%b state=%0d",
               ok, gate_open, entry_grant, exit_grant, gate_close, occupancy, lot_empty, lot_full, state);
    end
    step();
    rst = 1'b0;
    occ_m = 0;
    rr_m = LANE_ENTRY;
    exp_q.delete();
    step();
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_exit_when_empty();
    test_fill();
    test_alternate();
    test_timeout();
    test_reset_mid_open();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_lane_arbiter.md
Name: gate_lane_arbiter

Overview:
- Arbitrates one shared parking barrier gate between an entry lane and an exit lane.
- Sequences the gate open and close cycle for the lane that wins arbitration.
- Maintains lot occupancy and blocks entry when the lot is full.
- Sits downstream of the per-lane access controllers, which raise a request only after a vehicle is authenticated, and drives the barrier actuator.

Parameters:
- CAPACITY, 8: number of parking spaces; maximum occupancy value.
- TIMEOUT_CYCLES, 16: OPEN-state watchdog limit in clk cycles. Used only when GATE_TIMEOUT_EN is defined.
- OCC_W, $clog2(CAPACITY+1): occupancy counter width. Derived; do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- entry_req  input  1  level; authenticated vehicle waiting at the entry lane.
- exit_req  input  1  level; vehicle waiting at the exit lane.
- vehicle_passed  input  1  single-cycle pulse; gate sensor reports the vehicle has cleared.
- entry_grant  output  1  entry lane owns the gate.
- exit_grant  output  1  exit lane owns the gate.
- gate_open  output  1  drive barrier open.
- gate_close  output  1  single-cycle close command.
- occupancy  output  OCC_W  current number of parked vehicles.
- lot_full  output  1  occupancy == CAPACITY.
- lot_empty  output  1  occupancy == 0.
- timeout_alarm  output  1  single-cycle pulse on watchdog expiry; constant 0 without the macro.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - All grants, gate_open, gate_close, timeout_alarm = 0.
  - occupancy = 0, lot_empty = 1, lot_full = 0.
  - Round-robin pointer favours entry.
  - Reset asserted mid-OPEN drops gate_open immediately and leaves occupancy at 0.
- States: IDLE, OPEN, CLOSE. Outputs are Moore-decoded from registered state, owner and occupancy.
- Eligibility:
  - entry eligible = entry_req && !lot_full.
  - exit eligible = exit_req && !lot_empty.
  - An ineligible request is ignored and is not latched.
- IDLE:
  - No eligible request: stay in IDLE.
  - Exactly one eligible request: register that lane as owner and go to OPEN.
  - Both eligible: grant the lane not served last, then toggle the pointer.
- OPEN:
  - gate_open = 1, and the owner's grant = 1.
  - Requests are ignored; a deasserted request does not abort the cycle.
  - vehicle_passed = 1 -> go to CLOSE.
- CLOSE (exactly one cycle):
  - gate_close = 1; the owner's grant stays 1; gate_open = 0.
  - On exit from CLOSE, occupancy +1 for entry or -1 for exit (skipped after a timeout), then go to IDLE.
- Latency:
  - Request sampled at edge N -> grant and gate_open high from cycle N+1.
  - vehicle_passed at edge M -> gate_close high in cycle M+1.
  - Updated occupancy visible in cycle M+2, which is IDLE; a new grant is possible from cycle M+3.
- Arithmetic: occupancy never wraps. Saturation is guaranteed by eligibility; an assertion checks for it.
- vehicle_passed while in IDLE or CLOSE is ignored.

Optional Feature:
- Macro: GATE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering OPEN and increments each OPEN cycle.
  - When the counter reaches TIMEOUT_CYCLES with no vehicle_passed, go to CLOSE and pulse timeout_alarm in that CLOSE cycle.
  - Occupancy is not updated after a timeout.
  - If vehicle_passed and expiry fall in the same cycle, vehicle_passed wins: normal close, no alarm.
- Undefined: OPEN waits indefinitely; timeout_alarm is tied to 0; no counter logic is synthesized.

Decomposition:
- Package gate_pkg:
  - state encoding: IDLE = 2'b00, OPEN = 2'b01, CLOSE = 2'b10.
  - lane enum: LANE_ENTRY = 0, LANE_EXIT = 1.
  - default CAPACITY and TIMEOUT_CYCLES.
- Sub-module occupancy_counter:
  - inputs inc and dec; outputs count, full, empty.
  - parameter CAPACITY.
  - The arbiter FSM instantiates it.

Test Plan:
- Reset, then entry_req=1 for 1 cycle at cycle 2 -> entry_grant and gate_open high from cycle 3. vehicle_passed at cycle 6 -> gate_close in cycle 7, occupancy=1 in cycle 8.
- occupancy=0 with exit_req held high for 10 cycles -> no grant, state stays IDLE, lot_empty=1.
- Fill to 8 entries -> lot_full=1; a further entry_req is ignored; exit_req then grants exit and occupancy=7 after close.
- entry_req and exit_req both high continuously with occupancy=3 -> grants alternate entry, exit, entry; occupancy returns to 3 after each pair.
- GATE_TIMEOUT_EN defined, entry granted, no vehicle_passed -> CLOSE after 16 OPEN cycles, timeout_alarm pulses once, occupancy unchanged. Repeat with vehicle_passed on the expiry cycle -> no alarm, occupancy +1.
- rst asserted mid-OPEN with occupancy=5 -> outputs clear asynchronously, occupancy=0, state IDLE.
